alu_result_stage: RTL

- Execute-to-writeback pipeline stage directly downstream of the 4-bit-opcode ALU; consumes its result/carryout plus the issuing opcode and destination register.
- Registers one result per cycle through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains architectural Z/N/C status flags for branch logic.
- Output feeds the register-file write port.

---
 rtl/alu_result_stage_if.sv | 64 ++++++
 rtl/alu_result_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage_if.sv
// Execute-to-writeback bus for alu_result_stage: ALU-side input handshake,
// register-file-side output handshake and the architectural status flags.
// slave  : the result stage itself.
// master : the surrounding ALU / register-file environment.
interface alu_result_stage_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned RW = 5
);

  // ALU side
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [N-1:0]  in_result;
  logic          in_carry;
  logic [RW-1:0] in_rd;

  // Register-file side
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [RW-1:0] out_rd;
  logic          out_we;

  // Status flags for branch logic
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;

  modport slave (
    input  in_valid,
    input  in_opcode,
    input  in_result,
    input  in_carry,
    input  in_rd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_rd,
    output out_we,
    output flag_z,
    output flag_n,
    output flag_c
  );

  modport master (
    output in_valid,
    output in_opcode,
    output in_result,
    output in_carry,
    output in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_rd,
    input  out_we,
    input  flag_z,
    input  flag_n,
    input  flag_c
  );

endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage behind the ALU: a 2-entry skid buffer (main +
// skid register) with valid/ready on both sides, plus Z/N/C status flags that
// update in accept order.
// Optional build macro ALU_STAGE_R0_SUPPRESS_EN: when defined, words destined
// for register 0 still handshake but out_we is held low for them.
module alu_result_stage #(
  parameter int unsigned N  = 32,
  parameter int unsigned RW = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [N-1:0]  main_data_q;
  logic [N-1:0]  main_data_d;
  logic [RW-1:0] main_rd_q;
  logic [RW-1:0] main_rd_d;
  logic [N-1:0]  skid_data_q;
  logic [RW-1:0] skid_rd_q;
  logic          load_skid;

  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_we_q;
  logic          out_we_d;

  logic          flag_z_q;
  logic          flag_n_q;
  logic          flag_c_q;

  logic          accept;
  logic          fire;

  assign accept = bus.in_valid && in_ready_q;
  assign fire   = out_valid_q && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and main-register load selection
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    load_skid   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = bus.in_result;
          main_rd_d   = bus.in_rd;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_data_d = bus.in_result;
          main_rd_d   = bus.in_rd;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain of main can happen
        if (fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_rd_d   = skid_rd_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Write-enable qualifier for the word that will sit in main next cycle
  always_comb begin
    out_we_d = 1'b0;
`ifdef ALU_STAGE_R0_SUPPRESS_EN
    out_we_d = (state_d != EMPTY) && (main_rd_d != '0);
`else
    out_we_d = (state_d != EMPTY);
`endif
  end

  // Main and skid payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      if (load_skid) begin
        skid_data_q <= bus.in_result;
        skid_rd_q   <= bus.in_rd;
      end
    end
  end

  // Registered handshake outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
    end else begin
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      out_we_q    <= out_we_d;
    end
  end

  // Status flags follow accepted results; carry only tracks adds
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (accept) begin
      flag_z_q <= (bus.in_result == '0);
      flag_n_q <= bus.in_result[N-1];
      if (bus.in_opcode == OP_ADD) begin
        flag_c_q <= bus.in_carry;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_rd    = main_rd_q;
  assign bus.out_we    = out_we_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_c    = flag_c_q;

  // A full buffer must never advertise space
  a_full_not_ready : assert property (
    @(posedge clk) disable iff (rst) !((state_q == FULL) && in_ready_q)
  );

  // A stalled output word must not change underneath the register file
  a_stall_stable : assert property (
    @(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> ($stable(main_data_q) && $stable(main_rd_q))
  );

endmodule
